// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with prefetch queue, redirect, halt and restart
module instr_fetch_unit #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 17,
  parameter int ADDR_W  = 8
) (
  input  logic               uClk,
  input  logic               reset,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [4:0] OP_HALT    = 5'd30;
  localparam logic [4:0] OP_RESTART = 5'd31;

  typedef enum logic {RUN, HALT} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  fpc;
  logic [ADDR_W-1:0]  rd_addr;
  logic               inflight;
  logic [CW-1:0]      count;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];

  logic               accept, halt_acc, restart_acc, flush, push;
  logic [4:0]         head_op;
  logic [CW:0]        occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign instr_valid = (count != '0);
  assign imem_addr   = fpc;
  assign halted      = (state == HALT);

  // Handshake decode: accept, flush sources, read issue and data push
  always_comb begin
    accept      = instr_valid & instr_ready;
    head_op     = instr[INSTR_W-1 -: 5];
    halt_acc    = accept && (head_op == OP_HALT);
    restart_acc = accept && (head_op == OP_RESTART);
    flush       = redirect | halt_acc | restart_acc;
    // A returning read is dropped whenever the queue is flushed in the same cycle
    push        = inflight & ~flush;
    occupancy   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(accept);
    imem_rd     = 1'b0;
    if (!reset && state == RUN && !flush && occupancy < (CW+1)'(DEPTH))
      imem_rd = 1'b1;
  end

  // Next-state: redirect and restart force RUN, an accepted halt word parks in HALT
  always_comb begin
    state_next = state;
    if (redirect || restart_acc)
      state_next = RUN;
    else if (halt_acc)
      state_next = HALT;
  end

  // State register
  always_ff @(posedge uClk) begin
    if (reset)
      state <= RUN;
    else
      state <= state_next;
  end

  // Fetch PC, in-flight tracking and circular prefetch queue
  always_ff @(posedge uClk) begin
    if (reset) begin
      fpc      <= '0;
      rd_addr  <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        fpc     <= fpc + ADDR_W'(1);
        rd_addr <= fpc;
      end
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (redirect)
          fpc <= redirect_pc;
        else if (restart_acc)
          fpc <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]    <= rd_addr;
          wr_ptr          <= ptr_inc(wr_ptr);
        end
        if (accept)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push && !accept)
          count <= count + CW'(1);
        else if (accept && !push)
          count <= count - CW'(1);
      end
    end
  end

endmodule
